ram_large_ctrl: RTL and testbench

Request/response front end for the 4-bank large synchronous RAM (`single_port_sync_ram_large`), sitting directly upstream of it. Accepts one read or write request at a time over a valid/ready handshake and sequences the RAM's `addr`, `cs_input`, `we` and `oe` pins. Drives and releases the RAM's shared tri-state `data` bus. Returns write acknowledgements and captured read data as a one-cycle response pulse.

---
 rtl/ram_large_ctrl_if.sv | 55 +++++
 rtl/ram_large_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ram_large_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_large_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_large_ctrl_if
//
// Purpose:
//   Request/response channel between a requester and ram_large_ctrl. One
//   read or write request is handed over per valid/ready handshake, and each
//   completed request comes back as a single-cycle resp_valid pulse.
//
// Signals:
//   req_valid   requester -> controller  request present
//   req_ready   controller -> requester  controller can accept this cycle
//   req_we      requester -> controller  1 = write, 0 = read
//   req_addr    requester -> controller  word address (ADDR_WIDTH)
//   req_wdata   requester -> controller  write data (DATA_WIDTH)
//   resp_valid  controller -> requester  one-cycle completion pulse
//   resp_rdata  controller -> requester  read data, valid with resp_valid
//
// Modports:
//   master  the requester side
//   slave   the controller side
// ---------------------------------------------------------------------------
interface ram_large_ctrl_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata
    );

endinterface

// File: rtl/ram_large_ctrl.sv
// ---------------------------------------------------------------------------
// ram_large_ctrl
//
// Purpose:
//   Front end for the 4-bank single_port_sync_ram_large. Accepts one read or
//   write request at a time, sequences the RAM's addr/cs/we/oe pins, drives
//   the shared tri-state data bus only while writing, and returns a one-cycle
//   response pulse (with captured data for reads).
//
//   Write: accept -> WRITE -> RESP          (response 2 cycles after accept)
//   Read : accept -> READ -> READ_DATA -> RESP (response 3 cycles after accept)
//   A new request can be accepted in RESP, so back-to-back traffic runs at
//   one write per 2 cycles or one read per 3 cycles.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   bus        request/response channel (ram_large_ctrl_if.slave)
//   mem_addr   RAM word address (top 2 bits pick the bank inside the RAM)
//   mem_data   RAM shared data bus; driven here only in WRITE
//   mem_cs     RAM chip select
//   mem_we     RAM write enable
//   mem_oe     RAM output enable
// ---------------------------------------------------------------------------
module ram_large_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_large_ctrl_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_DATA,
        RESP
    } state_t;

    state_t                state_q,      state_d;
    logic                  ready_q,      ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic                  cs_q,         cs_d;
    logic                  we_q,         we_d;
    logic                  oe_q,         oe_d;
    logic                  drive_q,      drive_d;
    logic                  accept;

    // Next-state and next-output logic. Every pin is a registered Moore
    // output, so the values the pins will carry in the coming cycle are
    // decoded here from the state we are about to enter (state_d) and loaded
    // into their registers on the same edge as the state itself. This keeps
    // the RAM control pins glitch-free. The request is only looked at when
    // ready_q is high, which already restricts acceptance to IDLE and RESP.
    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cs_d         = 1'b0;
        we_d         = 1'b0;
        oe_d         = 1'b0;
        drive_d      = 1'b0;
        accept       = bus.req_valid & ready_q;

        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = bus.req_we ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE:     state_d = RESP;
            READ:      state_d = READ_DATA;
            READ_DATA: state_d = RESP;
            default:   state_d = IDLE;
        endcase

        // The requester may change its request the cycle after acceptance,
        // so address and data are captured here. mem_addr comes straight
        // from addr_q, which only changes on an accept and therefore holds
        // its last value through IDLE and RESP.
        if (accept) begin
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
        end

        // The RAM drives the bus throughout READ_DATA; sample it on the
        // edge that leaves READ_DATA.
        if (state_q == READ_DATA) begin
            rdata_d = mem_data;
        end

        unique case (state_d)
            IDLE: begin
                ready_d = 1'b1;
            end
            RESP: begin
                ready_d      = 1'b1;
                resp_valid_d = 1'b1;
            end
            WRITE: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                drive_d = 1'b1;
            end
            READ, READ_DATA: begin
                cs_d = 1'b1;
                oe_d = 1'b1;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset is asynchronous, so an in-flight
    // operation is abandoned immediately: the RAM pins drop, the bus is
    // released and no response is produced. ready_q resets low and first
    // rises on the edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            drive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cs_q         <= cs_d;
            we_q         <= we_d;
            oe_q         <= oe_d;
            drive_q      <= drive_d;
        end
    end

    // The bus is only ever driven in WRITE. The RAM only drives it in
    // READ_DATA, and RESP always sits between the two, so the sides never
    // overlap.
    assign mem_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign mem_addr       = addr_q;
    assign mem_cs         = cs_q;
    assign mem_we         = we_q;
    assign mem_oe         = oe_q;
    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_ram_large_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_large_ctrl
//
// Directed bench for ram_large_ctrl with a small behavioural model of the
// 4-bank synchronous RAM on the far side of the pins. Expected values are
// written out by hand at each step.
// ---------------------------------------------------------------------------
module tb_ram_large_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] memAddr;
    wire  [DW-1:0] memData;
    logic          memCs;
    logic          memWe;
    logic          memOe;

    int total = 0;
    int bad   = 0;

    ram_large_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_large_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_addr (memAddr),
        .mem_data (memData),
        .mem_cs   (memCs),
        .mem_we   (memWe),
        .mem_oe   (memOe)
    );

    always #5 clk = ~clk;

    // RAM model: stores on an edge with cs&we, registers a read on an edge
    // with cs&oe&!we and drives that word while oe stays high afterwards.
    logic [DW-1:0] ramArray [0:(1<<AW)-1];
    logic [DW-1:0] ramOut   = '0;
    logic          ramDrive = 1'b0;

    always @(posedge clk) begin
        if (memCs && memWe) ramArray[memAddr] <= memData;
        if (memCs && memOe && !memWe) ramOut <= ramArray[memAddr];
        ramDrive <= memCs && memOe && !memWe;
    end

    assign memData = (ramDrive && memOe) ? ramOut : {DW{1'bz}};

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutputBit(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Nobody driving: high-Z in a 4-state simulator, zero in a 2-state one.
    function automatic logic busFree();
        return $isunknown(memData) || (memData == '0);
    endfunction

    task automatic checkPins(input string tag, input logic cs, input logic we, input logic oe,
                             input logic ready, input logic respValid);
        checkOutputBit({tag, ".cs"},    memCs,          cs);
        checkOutputBit({tag, ".we"},    memWe,          we);
        checkOutputBit({tag, ".oe"},    memOe,          oe);
        checkOutputBit({tag, ".ready"}, bus.req_ready,  ready);
        checkOutputBit({tag, ".resp"},  bus.resp_valid, respValid);
    endtask

    task automatic applyStimulus(input logic valid, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        bus.req_valid = valid;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    // Starts at a falling edge with the controller in IDLE.
    task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        applyStimulus(1'b1, 1'b1, addr, data);
        @(negedge clk);
        checkPins("wr.write", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wr.addr", {{(DW-AW){1'b0}}, memAddr}, {{(DW-AW){1'b0}}, addr});
        checkOutput("wr.data", memData, data);
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkPins("wr.resp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutputBit("wr.busfree", busFree(), 1'b1);
        @(negedge clk);
        checkPins("wr.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic doRead(input logic [AW-1:0] addr, input logic [DW-1:0] expData);
        applyStimulus(1'b1, 1'b0, addr, '0);
        @(negedge clk);
        checkPins("rd.read", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rd.addr", {{(DW-AW){1'b0}}, memAddr}, {{(DW-AW){1'b0}}, addr});
        checkOutputBit("rd.busfree", busFree(), 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkPins("rd.data", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rd.bus", memData, expData);
        @(negedge clk);
        checkPins("rd.resp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rd.rdata", bus.resp_rdata, expData);
        checkOutput("rd.rdata.hi", {16'h0, bus.resp_rdata[31:16]}, {16'h0, expData[31:16]});
        checkOutput("rd.rdata.lo", {16'h0, bus.resp_rdata[15:0]}, {16'h0, expData[15:0]});
        @(negedge clk);
        checkPins("rd.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rd.hold", bus.resp_rdata, expData);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0);

        // Reset values while reset is held.
        @(negedge clk);
        checkPins("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.rdata", bus.resp_rdata, 32'h0);
        checkOutput("reset.addr", {{(DW-AW){1'b0}}, memAddr}, 32'h0);
        checkOutputBit("reset.busfree", busFree(), 1'b1);
        rst = 1'b0;

        // Idle after reset for 10 cycles: ready rises after the first edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkPins("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutputBit("idle.busfree", busFree(), 1'b1);
        end

        // Write then read back.
        doWrite(14'h0001, 32'hDEADBEEF);
        doRead(14'h0001, 32'hDEADBEEF);

        // One address per bank, including the very last word.
        doWrite(14'h0000, 32'h12345678);
        doWrite(14'h1000, 32'h9ABCDEF0);
        doWrite(14'h2000, 32'h0F0F0F0F);
        doWrite(14'h3FFF, 32'hCAFEF00D);
        doRead(14'h0000, 32'h12345678);
        doRead(14'h1000, 32'h9ABCDEF0);
        doRead(14'h2000, 32'h0F0F0F0F);
        doRead(14'h3FFF, 32'hCAFEF00D);
        doRead(14'h0001, 32'hDEADBEEF);

        // Back-to-back with req_valid held high; the read presented during
        // WRITE must wait for RESP.
        applyStimulus(1'b1, 1'b1, 14'h0010, 32'hA5A5A5A5);
        @(negedge clk);
        checkPins("b2b.write1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b.wdata1", memData, 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, 14'h0010, 32'h0);
        @(negedge clk);
        checkPins("b2b.resp1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkPins("b2b.read", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 14'h0010, 32'h5A5A5A5A);
        @(negedge clk);
        checkPins("b2b.rdata", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b.bus", memData, 32'hA5A5A5A5);
        @(negedge clk);
        checkPins("b2b.resp2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("b2b.rdata", bus.resp_rdata, 32'hA5A5A5A5);
        @(negedge clk);
        checkPins("b2b.write2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b.wdata2", memData, 32'h5A5A5A5A);
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkPins("b2b.resp3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("b2b.rdata.keep", bus.resp_rdata, 32'hA5A5A5A5);
        @(negedge clk);
        checkPins("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        doRead(14'h0010, 32'h5A5A5A5A);

        // Reset in the middle of a read.
        doWrite(14'h0077, 32'h13579BDF);
        applyStimulus(1'b1, 1'b0, 14'h0077, 32'h0);
        @(negedge clk);
        checkPins("rst.read", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("rst.bus.before", memData, 32'h13579BDF);
        #1 rst = 1'b1;
        #1;
        checkPins("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst.async.rdata", bus.resp_rdata, 32'h0);
        checkOutput("rst.async.addr", {{(DW-AW){1'b0}}, memAddr}, 32'h0);
        checkOutputBit("rst.async.busfree", busFree(), 1'b1);
        @(negedge clk);
        checkPins("rst.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkPins("rst.after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        doRead(14'h0077, 32'h13579BDF);
        doRead(14'h3FFF, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
